// File: rtl/rv32e_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32e_arb_pkg
//  Description : Shared types and constants for the RV32E instruction/data
//                memory arbiter (FSM states, grant owner, NOP word, timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32e_arb_pkg;

  // Arbiter FSM states: idle, instruction transfer, data transfer
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IBUS = 2'd1,
    ST_DBUS = 2'd2
  } arb_state_e;

  // Owner of the most recently completed transfer
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_e;

  // ADDI x0,x0,0 -- returned to the fetch port when a transfer times out
  localparam logic [31:0] ARB_NOP_WORD        = 32'h0000_0013;
  localparam int unsigned ARB_TIMEOUT_DEFAULT = 16;
  localparam logic [3:0]  ARB_BE_WORD         = 4'b1111;

endpackage : rv32e_arb_pkg
`default_nettype wire

// File: rtl/rv32e_arb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : rv32e_arb_watchdog
//  Description : Counts cycles a bus request waits for mem_ready. Fires a
//                one-cycle expire strobe on the TIMEOUT_CYCLES-th waiting
//                cycle and keeps a sticky bus_error flag until reset.
//                Only instantiated when ARB_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32e_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic busy_i,
  input  logic ready_i,
  output logic expire_o,
  output logic bus_error_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             bus_error_q;

  // Expire on the last allowed waiting cycle; a late ready still wins
  assign expire_o    = busy_i & ~ready_i & (cnt_q == CNT_LAST);
  assign bus_error_o = bus_error_q;

  // Next wait count: cleared whenever no transfer is stalled on memory
  always_comb begin
    cnt_d = cnt_q;
    if (!busy_i || ready_i || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait counter and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (expire_o) begin
        bus_error_q <= 1'b1;
      end
    end
  end

endmodule : rv32e_arb_watchdog
`default_nettype wire

// File: rtl/rv32e_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rv32e_mem_arbiter
//  Description : Shares one single-port memory between the RV32E fetch port
//                and data port. One outstanding transfer at a time, D-first
//                arbitration that alternates when both ports wait.
//                Optional macro ARB_TIMEOUT_EN adds a mem_ready watchdog that
//                completes a stuck transfer with a NOP/zero word and raises a
//                sticky bus_error.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32e_mem_arbiter
  import rv32e_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        imem_read,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        imem_valid,
  output logic        imem_stall,
  // data port
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_data_out,
  input  logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_data_in,
  output logic        dmem_valid,
  output logic        dmem_stall,
  // unified memory
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);

  arb_state_e  state_q;
  arb_grant_e  last_grant_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [31:0] imem_data_q;
  logic        imem_valid_q;
  logic [31:0] dmem_data_q;
  logic        dmem_valid_q;
  logic        d_pend;
  logic        i_pend;
  logic        wd_expire;

  assign i_pend = imem_read;
  assign d_pend = dmem_read | dmem_write;

`ifdef ARB_TIMEOUT_EN
  rv32e_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .busy_i      (mem_req_q),
    .ready_i     (mem_ready),
    .expire_o    (wd_expire),
    .bus_error_o (bus_error)
  );
`else
  // Without the watchdog a transfer waits for mem_ready indefinitely
  logic [31:0] unused_timeout_w;
  assign unused_timeout_w = TIMEOUT_CYCLES;
  assign wd_expire        = 1'b0;
  assign bus_error        = 1'b0;
`endif

  // Arbitration, request latching and completion; all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      imem_data_q  <= '0;
      imem_valid_q <= 1'b0;
      dmem_data_q  <= '0;
      dmem_valid_q <= 1'b0;
    end else begin
      imem_valid_q <= 1'b0;
      dmem_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // D wins unless it also won last time and I is waiting
          if (d_pend && (!i_pend || (last_grant_q != GRANT_D))) begin
            state_q     <= ST_DBUS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dmem_write;
            mem_addr_q  <= dmem_addr;
            mem_wdata_q <= dmem_write ? dmem_data_out : 32'h0;
            mem_be_q    <= dmem_write ? dmem_byte_enable : ARB_BE_WORD;
          end else if (i_pend) begin
            state_q     <= ST_IBUS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= imem_addr;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= ARB_BE_WORD;
          end
        end
        ST_IBUS: begin
          if (mem_ready || wd_expire) begin
            imem_data_q  <= mem_ready ? mem_rdata : ARB_NOP_WORD;
            imem_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            last_grant_q <= GRANT_I;
          end
        end
        ST_DBUS: begin
          if (mem_ready || wd_expire) begin
            dmem_data_q  <= mem_ready ? mem_rdata : 32'h0;
            dmem_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            last_grant_q <= GRANT_D;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign imem_data    = imem_data_q;
  assign imem_valid   = imem_valid_q;
  assign dmem_data_in = dmem_data_q;
  assign dmem_valid   = dmem_valid_q;

  // A port stalls while it asks and its completion pulse is not present
  assign imem_stall = imem_read & ~imem_valid_q;
  assign dmem_stall = (dmem_read | dmem_write) & ~dmem_valid_q;

endmodule : rv32e_mem_arbiter
`default_nettype wire

// File: doc/rv32e_mem_arbiter.md
RV32E_MEM_ARBITER -- requirements
Module: rv32e_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, mem_ready wait limit in cycles (used only with ARB_TIMEOUT_EN).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: imem_read  in  1  CPU instruction-fetch request, held until imem_valid.
REQ-005 Port: imem_addr  in  32  fetch byte address.
REQ-006 Port: imem_data  out  32  fetched instruction word.
REQ-007 Port: imem_valid  out  1  one-cycle pulse; imem_data valid.
REQ-008 Port: dmem_read / dmem_write  in  1 each  CPU data request, held until dmem_valid.
REQ-009 Port: dmem_addr, dmem_data_out  in  32 each  data address, store data.
REQ-010 Port: dmem_byte_enable  in  4  store byte lanes.
REQ-011 Port: dmem_data_in  out  32  load data; dmem_valid  out  1  one-cycle completion pulse (loads and stores).
REQ-012 Port: imem_stall, dmem_stall  out  1 each  port pending and not completing this cycle.
REQ-013 Port: mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32; mem_be  out  4  unified single-port memory request.
REQ-014 Port: mem_ready  in  1; mem_rdata  in  32  memory completion and read data.
REQ-015 Port: bus_error  out  1  sticky timeout flag (ARB_TIMEOUT_EN only; else tied 0).

Function
REQ-016 FSM states IDLE, IBUS, DBUS; one outstanding memory transaction maximum.
REQ-017 IDLE: D pending (dmem_read|dmem_write) and I not pending -> DBUS; I only -> IBUS; none -> stay.
REQ-018 Both pending in IDLE: grant D unless last_grant==D, then grant I (alternating; neither starves).
REQ-019 On grant, latch address/wdata/be/we into registers; mem_req asserted from the next cycle, held with stable fields until mem_ready.
REQ-020 mem_we=1 only for dmem_write; mem_be=4'b1111 for reads; dmem_read and dmem_write together treated as write.
REQ-021 Cycle with mem_req&mem_ready: register mem_rdata to imem_data/dmem_data_in, pulse matching valid next cycle, return to IDLE, update last_grant.
REQ-022 Minimum latency: request cycle N, mem_req N+1, mem_ready N+1 -> valid at N+2; back-to-back grant possible at N+2.
REQ-023 imem_data/dmem_data_in hold last value until next completion of same port.
REQ-024 imem_stall = imem_read & ~imem_valid; dmem_stall = (dmem_read|dmem_write) & ~dmem_valid; combinational.
REQ-025 mem_ready while mem_req low ignored; requests deasserted mid-transaction do not abort the bus cycle (result discarded, valid still pulses).

Reset
REQ-026 Reset: state IDLE, last_grant=I, mem_req/mem_we/valids/bus_error 0, mem_addr/mem_wdata/data outputs 0, mem_be 0.
REQ-027 Reset mid-transaction drops mem_req next cycle; no valid pulse produced for the aborted transfer.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN defined: counter increments each cycle mem_req high without mem_ready; at TIMEOUT_CYCLES sets bus_error, pulses the pending port's valid with data 32'h0000_0013 (I) or 0 (D), returns IDLE.
REQ-029 ARB_TIMEOUT_EN undefined: no counter; transaction waits indefinitely; bus_error constant 0.

Structure
REQ-030 Shared package rv32e_arb_pkg: state enumeration, ARB_NOP_WORD (32'h0000_0013), default TIMEOUT_CYCLES.
REQ-031 Optional sub-module rv32e_arb_watchdog holds the timeout counter, instantiated only under ARB_TIMEOUT_EN.

Verification
REQ-032 imem_read, addr 0x08, mem_ready one cycle after mem_req, rdata 0x00208863 -> imem_valid at N+2, imem_data 0x00208863.
REQ-033 dmem_write addr 0x40, data 0xDEADBEEF, be 4'b0011 -> mem_we=1, mem_be=0011, mem_wdata 0xDEADBEEF; dmem_valid one cycle after mem_ready.
REQ-034 imem_read and dmem_read held together from reset -> grants D, I, D, I alternate; neither stall exceeds two transactions.
REQ-035 mem_ready delayed 5 cycles -> mem_req/mem_addr stable 5 cycles, imem_stall high throughout, valid one cycle after ready.
REQ-036 Reset asserted while in DBUS -> mem_req 0 next cycle, no dmem_valid, state IDLE.
REQ-037 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ready never -> bus_error set after 16 cycles, imem_valid with data 0x00000013.
